// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters and
// tree-PLRU replacement. Lookup is combinational against registered state;
// updates from execute are written on the rising clock edge.

package riscv_pkg;
  parameter int unsigned XLEN = 32;
endpackage

module btb_assoc #(
  parameter int unsigned SETS = 16,
  parameter int unsigned WAYS = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [riscv_pkg::XLEN-1:0] i_pc_if,
  input  logic                       i_lookup_en,
  input  logic                       i_flush_en,
  input  logic                       i_update_en,
  input  logic [riscv_pkg::XLEN-1:0] i_pc_update,
  input  logic [riscv_pkg::XLEN-1:0] i_target_update,
  input  logic [1:0]                 i_type_update,
  input  logic                       i_taken_update,
  output logic                       o_hit_valid,
  output logic [riscv_pkg::XLEN-1:0] o_target_predict,
  output logic                       o_pred_taken,
  output logic [1:0]                 o_hit_type,
  output logic [riscv_pkg::XLEN-1:0] o_pc_hit
);

  localparam int unsigned XLEN = riscv_pkg::XLEN;
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAG  = XLEN - IDX - 2;
  localparam int unsigned WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  // At least one bit of PLRU storage so the array is legal when WAYS=1.
  localparam int unsigned PW   = (WAYS > 1) ? WAYS - 1 : 1;

  // Valid and PLRU are reset; payload arrays are not.
  logic [WAYS-1:0] r_valid  [SETS];
  logic [PW-1:0]   r_plru   [SETS];
  logic [TAG-1:0]  r_tag    [SETS][WAYS];
  logic [XLEN-1:0] r_target [SETS][WAYS];
  logic [1:0]      r_type   [SETS][WAYS];
  logic [1:0]      r_ctr    [SETS][WAYS];

  logic [IDX-1:0]  w_lk_idx;
  logic [TAG-1:0]  w_lk_tag;
  logic            w_lk_hit;
  logic [WW-1:0]   w_lk_way;
  logic [1:0]      w_lk_type;
  logic [1:0]      w_lk_ctr;

  logic [IDX-1:0]  w_up_idx;
  logic [TAG-1:0]  w_up_tag;
  logic            w_up_hit;
  logic [WW-1:0]   w_up_way;
  logic            w_has_inv;
  logic [WW-1:0]   w_inv_way;
  logic [WW-1:0]   w_victim;
  logic [WW-1:0]   w_wr_way;
  logic [PW-1:0]   w_plru_cur;
  logic [PW-1:0]   w_plru_nxt;
  logic [1:0]      w_ctr_cur;
  logic [1:0]      w_ctr_nxt;
  logic            w_do_write;

  assign w_lk_idx = i_pc_if[IDX+1:2];
  assign w_lk_tag = i_pc_if[XLEN-1:IDX+2];
  assign w_up_idx = i_pc_update[IDX+1:2];
  assign w_up_tag = i_pc_update[XLEN-1:IDX+2];

  // Lookup tag compare; at most one way can match.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
        w_lk_hit = i_lookup_en;
        w_lk_way = WW'(w);
      end
    end
  end

  assign w_lk_type = r_type[w_lk_idx][w_lk_way];
  assign w_lk_ctr  = r_ctr[w_lk_idx][w_lk_way];

  // Prediction outputs; a miss falls through to the sequential PC.
  always_comb begin
    o_hit_valid      = w_lk_hit;
    o_target_predict = w_lk_hit ? r_target[w_lk_idx][w_lk_way] : i_pc_if + XLEN'(4);
    o_pc_hit         = w_lk_hit ? i_pc_if : '0;
    o_hit_type       = w_lk_hit ? w_lk_type : 2'b00;
    o_pred_taken     = w_lk_hit && ((w_lk_type != 2'b00) || w_lk_ctr[1]);
  end

  // Update-side tag compare and lowest-index invalid way search.
  always_comb begin
    w_up_hit  = 1'b0;
    w_up_way  = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = WW'(w);
      end
      if (!r_valid[w_up_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WW'(w);
      end
    end
  end

  assign w_plru_cur = r_plru[w_up_idx];
  assign w_wr_way   = w_up_hit ? w_up_way : (w_has_inv ? w_inv_way : w_victim);

  // Tree-PLRU: bit 0 is the root; a 0 steers the victim toward the lower half.
  generate
    if (WAYS == 4) begin : g_plru4
      assign w_victim   = w_plru_cur[0] ? (w_plru_cur[2] ? 2'd3 : 2'd2)
                                        : (w_plru_cur[1] ? 2'd1 : 2'd0);
      assign w_plru_nxt = {w_wr_way[1] ? ~w_wr_way[0] : w_plru_cur[2],
                           w_wr_way[1] ? w_plru_cur[1] : ~w_wr_way[0],
                           ~w_wr_way[1]};
    end else if (WAYS == 2) begin : g_plru2
      assign w_victim   = w_plru_cur[0];
      assign w_plru_nxt = ~w_wr_way[0];
    end else begin : g_plru1
      assign w_victim   = '0;
      assign w_plru_nxt = '0;
    end
  endgenerate

  assign w_ctr_cur = r_ctr[w_up_idx][w_up_way];

  // Saturating counter step on a hit; fresh allocations start weakly taken.
  always_comb begin
    w_ctr_nxt = 2'b10;
    if (w_up_hit) begin
      if (i_taken_update) begin
        w_ctr_nxt = (w_ctr_cur == 2'b11) ? 2'b11 : w_ctr_cur + 2'd1;
      end else begin
        w_ctr_nxt = (w_ctr_cur == 2'b00) ? 2'b00 : w_ctr_cur - 2'd1;
      end
    end
  end

  // Flush and reset both suppress the write entirely.
  assign w_do_write = i_reset && i_update_en && !i_flush_en && (w_up_hit || i_taken_update);

  // Valid bits and PLRU state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else if (i_flush_en) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else if (w_do_write) begin
      r_valid[w_up_idx][w_wr_way] <= 1'b1;
      r_plru[w_up_idx]            <= w_plru_nxt;
    end
  end

  // Entry payload; survives flush.
  always_ff @(posedge i_clk) begin
    if (w_do_write) begin
      r_tag[w_up_idx][w_wr_way]    <= w_up_tag;
      r_target[w_up_idx][w_wr_way] <= i_target_update;
      r_type[w_up_idx][w_wr_way]   <= i_type_update;
      r_ctr[w_up_idx][w_wr_way]    <= w_ctr_nxt;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc (SETS=16, WAYS=2): stimulus queues the
// expected lookup response, a negedge monitor pops and compares it.

module tb_btb_assoc;

  logic        clk;
  logic        reset;
  logic [31:0] pc_if;
  logic        lookup_en;
  logic        flush_en;
  logic        update_en;
  logic [31:0] pc_update;
  logic [31:0] target_update;
  logic [1:0]  type_update;
  logic        taken_update;
  logic        hit_valid;
  logic [31:0] target_predict;
  logic        pred_taken;
  logic [1:0]  hit_type;
  logic [31:0] pc_hit;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       nm;
    logic        hit;
    logic [31:0] tgt;
    logic        pt;
    logic [1:0]  ty;
    logic [31:0] pch;
  } exp_t;

  exp_t exp_q[$];

  btb_assoc #(
    .SETS (16),
    .WAYS (2)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_pc_if         (pc_if),
    .i_lookup_en     (lookup_en),
    .i_flush_en      (flush_en),
    .i_update_en     (update_en),
    .i_pc_update     (pc_update),
    .i_target_update (target_update),
    .i_type_update   (type_update),
    .i_taken_update  (taken_update),
    .o_hit_valid     (hit_valid),
    .o_target_predict(target_predict),
    .o_pred_taken    (pred_taken),
    .o_hit_type      (hit_type),
    .o_pc_hit        (pc_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against every queued expectation.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "hit", 32'(hit_valid), 32'(e.hit));
      chk(e.nm, "target", target_predict, e.tgt);
      chk(e.nm, "pred_taken", 32'(pred_taken), 32'(e.pt));
      chk(e.nm, "type", 32'(hit_type), 32'(e.ty));
      chk(e.nm, "pc_hit", pc_hit, e.pch);
    end
  end

  task automatic set_up(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [1:0] ty, input logic tk);
    update_en     = 1'b1;
    pc_update     = pc;
    target_update = tgt;
    type_update   = ty;
    taken_update  = tk;
  endtask

  task automatic expect_lk(input string nm, input logic [31:0] pc, input logic hit,
                           input logic [31:0] tgt, input logic pt, input logic [1:0] ty);
    exp_t e;
    lookup_en = 1'b1;
    pc_if     = pc;
    e.nm  = nm;
    e.hit = hit;
    e.tgt = tgt;
    e.pt  = pt;
    e.ty  = ty;
    e.pch = hit ? pc : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    update_en    = 1'b0;
    flush_en     = 1'b0;
    lookup_en    = 1'b0;
    taken_update = 1'b0;
    pc_if        = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    pc_if         = 32'h0;
    lookup_en     = 1'b0;
    flush_en      = 1'b0;
    update_en     = 1'b0;
    pc_update     = 32'h0;
    target_update = 32'h0;
    type_update   = 2'b00;
    taken_update  = 1'b0;

    expect_lk("in_reset", 32'h100, 1'b0, 32'h104, 1'b0, 2'b00);
    step();
    reset = 1'b1;
    expect_lk("post_reset", 32'h100, 1'b0, 32'h104, 1'b0, 2'b00);
    step();

    // Allocation is not visible in the update cycle.
    set_up(32'h100, 32'h200, 2'b00, 1'b1);
    expect_lk("no_bypass", 32'h100, 1'b0, 32'h104, 1'b0, 2'b00);
    step();
    expect_lk("alloc_ctr10", 32'h100, 1'b1, 32'h200, 1'b1, 2'b00);
    step();
    pc_if = 32'h100;
    begin
      exp_t e;
      e.nm = "lookup_off"; e.hit = 1'b0; e.tgt = 32'h104; e.pt = 1'b0; e.ty = 2'b00;
      e.pch = 32'h0;
      exp_q.push_back(e);
    end
    step();

    // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10.
    set_up(32'h100, 32'h200, 2'b00, 1'b0);
    expect_lk("nt1_pre", 32'h100, 1'b1, 32'h200, 1'b1, 2'b00);
    step();
    set_up(32'h100, 32'h200, 2'b00, 1'b0);
    expect_lk("ctr01", 32'h100, 1'b1, 32'h200, 1'b0, 2'b00);
    step();
    set_up(32'h100, 32'h200, 2'b00, 1'b0);
    expect_lk("ctr00", 32'h100, 1'b1, 32'h200, 1'b0, 2'b00);
    step();
    set_up(32'h100, 32'h200, 2'b00, 1'b1);
    expect_lk("ctr00_sat", 32'h100, 1'b1, 32'h200, 1'b0, 2'b00);
    step();
    set_up(32'h100, 32'h200, 2'b00, 1'b1);
    expect_lk("ctr01_inc", 32'h100, 1'b1, 32'h200, 1'b0, 2'b00);
    step();
    expect_lk("ctr10_inc", 32'h100, 1'b1, 32'h200, 1'b1, 2'b00);
    step();

    // Set 0 fill and PLRU eviction of 0x100.
    set_up(32'h140, 32'h240, 2'b01, 1'b1);
    step();
    set_up(32'h180, 32'h280, 2'b10, 1'b1);
    expect_lk("way1_hit", 32'h140, 1'b1, 32'h240, 1'b1, 2'b01);
    step();
    expect_lk("evicted", 32'h100, 1'b0, 32'h104, 1'b0, 2'b00);
    step();
    expect_lk("keep_140", 32'h140, 1'b1, 32'h240, 1'b1, 2'b01);
    step();
    expect_lk("new_180", 32'h180, 1'b1, 32'h280, 1'b1, 2'b10);
    step();

    // Not-taken miss leaves everything alone.
    set_up(32'h300, 32'h900, 2'b00, 1'b0);
    step();
    expect_lk("nt_absent", 32'h300, 1'b0, 32'h304, 1'b0, 2'b00);
    step();
    expect_lk("nt_no_evict", 32'h180, 1'b1, 32'h280, 1'b1, 2'b10);
    step();

    // jal stays predicted taken with ctr=00.
    set_up(32'h140, 32'h240, 2'b01, 1'b0);
    step();
    set_up(32'h140, 32'h240, 2'b01, 1'b0);
    step();
    expect_lk("jal_ctr00", 32'h140, 1'b1, 32'h240, 1'b1, 2'b01);
    step();

    // Low PC bits ignored; return type in set 1.
    set_up(32'h104, 32'h500, 2'b11, 1'b1);
    step();
    expect_lk("ret_lowbits", 32'h107, 1'b1, 32'h500, 1'b1, 2'b11);
    step();
    expect_lk("wrap_pc4", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0, 2'b00);
    step();

    // Flush wins over a simultaneous update.
    flush_en = 1'b1;
    set_up(32'h600, 32'h610, 2'b01, 1'b1);
    expect_lk("pre_flush", 32'h180, 1'b1, 32'h280, 1'b1, 2'b10);
    step();
    expect_lk("flush_140", 32'h140, 1'b0, 32'h144, 1'b0, 2'b00);
    step();
    expect_lk("flush_180", 32'h180, 1'b0, 32'h184, 1'b0, 2'b00);
    step();
    expect_lk("flush_104", 32'h107, 1'b0, 32'h10B, 1'b0, 2'b00);
    step();
    expect_lk("flush_drop", 32'h600, 1'b0, 32'h604, 1'b0, 2'b00);
    step();

    // Reset mid-update clears valid and aborts the write.
    set_up(32'h700, 32'h710, 2'b00, 1'b1);
    step();
    expect_lk("pre_rst_hit", 32'h700, 1'b1, 32'h710, 1'b1, 2'b00);
    step();
    set_up(32'h740, 32'h750, 2'b01, 1'b1);
    reset = 1'b0;
    expect_lk("rst_async", 32'h700, 1'b0, 32'h704, 1'b0, 2'b00);
    step();
    reset = 1'b1;
    expect_lk("rst_abort", 32'h740, 1'b0, 32'h744, 1'b0, 2'b00);
    step();
    expect_lk("rst_clear", 32'h700, 1'b0, 32'h704, 1'b0, 2'b00);
    step();

    @(negedge clk);
    #1;
    chk("scoreboard", "drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
